// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, clock mode constants and default word width.
// Used by both the master and the slave-side blocks of the link.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_e;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b1;
    localparam int   DEFAULT_DATA_W = 8;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake and SPI pin bundle for the SPI master.
// The master modport is the view taken by spi_master; slave is the opposite end.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, tx_data, miso,
        output rx_data, busy, done, sclk, cs, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  rx_data, busy, done, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period counter producing the sclk level and one-cycle
// rise/fall strobes that coincide with the clk edge on which sclk toggles.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    always_comb begin
        tick   = en && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            // Leaving SHIFT parks sclk at its idle level and restarts the half-period.
            cnt_d  = '0;
            sclk_d = CPOL;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            sclk_q <= CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = tick && (sclk_q == CPOL);
    assign fall = tick && (sclk_q != CPOL);
endmodule

// File: rtl/spi_master.sv
// SPI master (CPOL=0, CPHA=1, LSB first): one full-duplex DATA_W-bit transfer per accepted start,
// framed by CLK_DIV cycles of cs setup and cs hold around the shifting phase.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = 2
) (
    input  logic            clk,
    input  logic            reset,
    spi_master_if.master    bus
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(CLK_DIV - 1);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic sclk, rise, fall;
    logic launch, sample, accept;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == ST_SHIFT),
        .sclk  (sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // With CPHA=1 data is launched on the leading sclk edge and sampled on the trailing one.
    assign launch = CPHA ? rise : fall;
    assign sample = CPHA ? fall : rise;
    assign accept = (state_q == ST_IDLE) && bus.start;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        wait_d    = wait_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        busy_d    = (state_q != ST_IDLE) || accept;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = bus.tx_data;
                    cs_d    = 1'b0;
                    wait_d  = '0;
                    edge_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (wait_q == LAST_WAIT) begin
                    wait_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (launch) begin
                    mosi_d = shift_q[0];
                end
                if (sample) begin
                    shift_d = {bus.miso, shift_q[DATA_W-1:1]};
                end
                if (launch || sample) begin
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        edge_d = edge_q + EW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (wait_q == LAST_WAIT) begin
                    wait_d    = '0;
                    cs_d      = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = shift_q;
                    mosi_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset clears everything so an aborted transfer leaves no partial word behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            wait_q    <= '0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            wait_q    <= wait_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk    = sclk;
    assign bus.cs      = cs_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural CPHA=1 LSB-first slave driving miso on rising sclk and capturing mosi on falling sclk.
module tb_spi_master;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(8)) bif1 ();
    spi_master_if #(.DATA_W(8)) bif2 ();

    spi_master #(.DATA_W(8), .CLK_DIV(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif1)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif2)
    );

    int passed = 0;
    int total  = 0;

    // Slave + monitor for dut1
    logic [7:0] pre1 = 8'h00, slave_tx1 = 8'h00, slave_rx1 = 8'h00;
    logic [7:0] mosi_bits1 = 8'h00, last_bits1 = 8'h00;
    logic       miso_s1 = 1'b0, force1 = 1'b0, sclk_prev1 = 1'b0, cs_prev1 = 1'b1;
    int         rise_in1 = 0, falls_in1 = 0, last_rises1 = 0;
    int         done_cnt1 = 0, cs_sclk_bad1 = 0, pre_mosi_bad1 = 0;

    assign bif1.miso = force1 ? 1'b1 : miso_s1;

    always @(negedge clk) begin
        if (bif1.cs) begin
            slave_tx1 = pre1;
            if (!cs_prev1) begin
                last_rises1 = rise_in1;
                last_bits1  = mosi_bits1;
            end
            rise_in1   = 0;
            falls_in1  = 0;
            mosi_bits1 = 8'h00;
        end else begin
            if (bif1.sclk && !sclk_prev1) begin
                miso_s1   = slave_tx1[0];
                slave_tx1 = slave_tx1 >> 1;
                if (rise_in1 < 8) mosi_bits1[rise_in1] = bif1.mosi;
                rise_in1++;
            end
            if (!bif1.sclk && sclk_prev1) begin
                slave_rx1 = {bif1.mosi, slave_rx1[7:1]};
                falls_in1++;
            end
            if (rise_in1 == 0 && bif1.mosi) pre_mosi_bad1++;
        end
        if ((bif1.cs != cs_prev1) && bif1.sclk) cs_sclk_bad1++;
        if (bif1.done) done_cnt1++;
        sclk_prev1 = bif1.sclk;
        cs_prev1   = bif1.cs;
    end

    // Slave + sclk period monitor for dut2
    logic [7:0] pre2 = 8'h00, slave_tx2 = 8'h00, slave_rx2 = 8'h00;
    logic       miso_s2 = 1'b0, sclk_prev2 = 1'b0, have_rise2 = 1'b0;
    int         cyc2 = 0, last_rise2 = 0, period2 = 0;

    assign bif2.miso = miso_s2;

    always @(negedge clk) begin
        cyc2++;
        if (bif2.cs) begin
            slave_tx2  = pre2;
            have_rise2 = 1'b0;
        end else begin
            if (bif2.sclk && !sclk_prev2) begin
                miso_s2   = slave_tx2[0];
                slave_tx2 = slave_tx2 >> 1;
                if (have_rise2) period2 = cyc2 - last_rise2;
                last_rise2 = cyc2;
                have_rise2 = 1'b1;
            end
            if (!bif2.sclk && sclk_prev2) slave_rx2 = {bif2.mosi, slave_rx2[7:1]};
        end
        sclk_prev2 = bif2.sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issues one start, optionally swaps tx_data right after acceptance, and returns
    // the cycle index (1 = cycle after the accepting edge) at which done is seen.
    task automatic run(input bit two, input logic [7:0] tx, input logic [7:0] alt, output int cyc);
        step();
        if (two) begin bif2.tx_data = tx; bif2.start = 1'b1; end
        else     begin bif1.tx_data = tx; bif1.start = 1'b1; end
        @(posedge clk);
        #1;
        if (two) begin bif2.start = 1'b0; bif2.tx_data = alt; end
        else     begin bif1.start = 1'b0; bif1.tx_data = alt; end
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (two ? bif2.done : bif1.done) break;
        end
    endtask

    initial begin
        int cyc, d0, gaps;
        bif1.start = 1'b0; bif1.tx_data = 8'h00;
        bif2.start = 1'b0; bif2.tx_data = 8'h00;

        // Reset state
        repeat (3) step();
        chk("rst_cs",   bif1.cs, 1);
        chk("rst_sclk", bif1.sclk, 0);
        chk("rst_mosi", bif1.mosi, 0);
        chk("rst_busy", bif1.busy, 0);
        chk("rst_done", bif1.done, 0);
        chk("rst_rx",   bif1.rx_data, 8'h00);
        chk("rst_cs2",  bif2.cs, 1);
        reset = 1'b1;
        repeat (2) step();

        // Loopback A5 / 3C
        pre1 = 8'h3C;
        d0 = done_cnt1;
        run(1'b0, 8'hA5, 8'hA5, cyc);
        chk("t1_latency", cyc, 37);
        chk("t1_rx",      bif1.rx_data, 8'h3C);
        chk("t1_busy_at_done", bif1.busy, 1);
        step();
        chk("t1_done_pulse", bif1.done, 0);
        chk("t1_busy_after", bif1.busy, 0);
        chk("t1_slave_rx",   slave_rx1, 8'hA5);
        chk("t1_done_cnt",   done_cnt1 - d0, 1);

        // Bit order / phase with miso tied high
        force1 = 1'b1;
        run(1'b0, 8'h01, 8'h01, cyc);
        step();
        force1 = 1'b0;
        chk("t2_rx",        bif1.rx_data, 8'hFF);
        chk("t2_mosi_bits", last_bits1, 8'h01);
        chk("t2_rises",     last_rises1, 8);
        chk("t2_pre_mosi",  pre_mosi_bad1, 0);
        chk("t2_cs_sclk",   cs_sclk_bad1, 0);

        // start held high across a transfer
        pre1 = 8'h11;
        d0 = done_cnt1;
        step();
        bif1.tx_data = 8'h22;
        bif1.start = 1'b1;
        @(posedge clk);
        #1;
        gaps = 0;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            cyc++;
            if (!bif1.busy) gaps++;
            if (bif1.done) break;
        end
        chk("t3_latency1", cyc, 37);
        chk("t3_one_done", done_cnt1 - d0, 1);
        chk("t3_cs_gap",   bif1.cs, 1);
        step();
        bif1.start = 1'b0;
        chk("t3_restart_cs",   bif1.cs, 0);
        chk("t3_restart_busy", bif1.busy, 1);
        cyc = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            cyc++;
            if (!bif1.busy) gaps++;
            if (bif1.done) break;
        end
        chk("t3_latency2", cyc, 37);
        chk("t3_busy_gaps", gaps, 0);
        chk("t3_rx",       bif1.rx_data, 8'h11);
        chk("t3_slave_rx", slave_rx1, 8'h22);
        repeat (3) step();
        chk("t3_done_cnt", done_cnt1 - d0, 2);
        chk("t3_idle",     bif1.busy, 0);

        // Asynchronous reset after the 4th falling sclk
        pre1 = 8'h00;
        d0 = done_cnt1;
        step();
        bif1.tx_data = 8'hF0;
        bif1.start = 1'b1;
        @(posedge clk);
        #1;
        bif1.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (falls_in1 >= 4) break;
        end
        chk("t4_reached_fall4", falls_in1, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_cs",   bif1.cs, 1);
        chk("t4_sclk", bif1.sclk, 0);
        chk("t4_busy", bif1.busy, 0);
        chk("t4_rx",   bif1.rx_data, 8'h00);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        chk("t4_no_done",  done_cnt1 - d0, 0);
        chk("t4_rx_after", bif1.rx_data, 8'h00);
        pre1 = 8'hC5;
        run(1'b0, 8'h5A, 8'h5A, cyc);
        chk("t4_latency",  cyc, 37);
        chk("t4_rx_clean", bif1.rx_data, 8'hC5);
        step();
        chk("t4_slave_rx", slave_rx1, 8'h5A);

        // CLK_DIV = 1
        pre2 = 8'h96;
        run(1'b1, 8'hC3, 8'hC3, cyc);
        chk("t5_latency", cyc, 19);
        chk("t5_rx",      bif2.rx_data, 8'h96);
        step();
        chk("t5_slave_rx", slave_rx2, 8'hC3);
        chk("t5_period",   period2, 2);
        chk("t5_busy",     bif2.busy, 0);

        // tx_data change after acceptance
        pre1 = 8'h69;
        run(1'b0, 8'h00, 8'hFF, cyc);
        step();
        chk("t6_slave_rx", slave_rx1, 8'h00);
        chk("t6_rx",       bif1.rx_data, 8'h69);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
